// File: rtl/fcmp_pkg.sv
// Shared definitions for the FloPoCo floating-point compare pipeline:
// exception encodings, predicate opcodes, decoded-operand record and word width.
package fcmp_pkg;

    localparam logic [1:0] EXC_ZERO = 2'b00;
    localparam logic [1:0] EXC_NORM = 2'b01;
    localparam logic [1:0] EXC_INF  = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    typedef enum logic [2:0] {
        OP_LT    = 3'd0,
        OP_LE    = 3'd1,
        OP_EQ    = 3'd2,
        OP_NE    = 3'd3,
        OP_GT    = 3'd4,
        OP_GE    = 3'd5,
        OP_UNORD = 3'd6,
        OP_ORD   = 3'd7
    } fcmp_op_e;

    // Exception class and sign survive stage 1; the magnitude is reduced to lt/gt there.
    typedef struct packed {
        logic [1:0] exc;
        logic       sign;
    } fcmp_dec_t;

    function automatic int fcmp_width(input int we, input int wf);
        return we + wf + 3;
    endfunction

endpackage

// File: rtl/fcmp_pipe_if.sv
// Operand/result handshake bundle for fcmp_pipe; slave is the comparator side,
// master is the producer/consumer side.
interface fcmp_pipe_if #(
    parameter int WE = 3,
    parameter int WF = 3
);
    localparam int W = fcmp_pkg::fcmp_width(WE, WF);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic         result;
    logic         lt;
    logic         eq;
    logic         gt;
    logic         unordered;
    logic [15:0]  unord_cnt;

    modport slave (
        input  in_valid, X, Y, op, out_ready,
        output in_ready, out_valid, result, lt, eq, gt, unordered, unord_cnt
    );

    modport master (
        output in_valid, X, Y, op, out_ready,
        input  in_ready, out_valid, result, lt, eq, gt, unordered, unord_cnt
    );

endinterface

// File: rtl/fcmp_expfrac_cmp.sv
// Unsigned magnitude compare of the packed {exp,frac} fields of two operands.
module fcmp_expfrac_cmp #(
    parameter int W = 6
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         lt_o,
    output logic         gt_o
);

    assign lt_o = (a_i < b_i);
    assign gt_o = (a_i > b_i);

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage valid/ready floating-point comparator for FloPoCo-format operands.
// Optional saturating unordered-result counter enabled by `define FCMP_UNORD_CNT_EN.
module fcmp_pipe
    import fcmp_pkg::*;
#(
    parameter int WE = 3,
    parameter int WF = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    fcmp_pipe_if.slave  bus
);

    localparam int W  = fcmp_width(WE, WF);
    localparam int MW = WE + WF;

    fcmp_dec_t  x_dec, y_dec;
    logic [MW-1:0] x_mag, y_mag;
    logic       mag_lt, mag_gt;

    assign x_dec = '{exc: bus.X[W-1 -: 2], sign: bus.X[MW]};
    assign y_dec = '{exc: bus.Y[W-1 -: 2], sign: bus.Y[MW]};
    assign x_mag = bus.X[MW-1:0];
    assign y_mag = bus.Y[MW-1:0];

    fcmp_expfrac_cmp #(.W(MW)) u_cmp (
        .a_i  (x_mag),
        .b_i  (y_mag),
        .lt_o (mag_lt),
        .gt_o (mag_gt)
    );

    // stage 1 registers
    logic      s1_valid_q, s1_valid_d;
    fcmp_dec_t s1_x_q, s1_x_d;
    fcmp_dec_t s1_y_q, s1_y_d;
    logic      s1_mlt_q, s1_mlt_d;
    logic      s1_mgt_q, s1_mgt_d;
    fcmp_op_e  s1_op_q, s1_op_d;

    // stage 2 registers
    logic out_valid_q, out_valid_d;
    logic result_q, result_d;
    logic lt_q, lt_d;
    logic eq_q, eq_d;
    logic gt_q, gt_d;
    logic un_q, un_d;

    logic s1_adv;
    logic in_ready;

    assign s1_adv   = ~out_valid_q | bus.out_ready;
    assign in_ready = ~s1_valid_q | s1_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_mlt_d   = s1_mlt_q;
        s1_mgt_d   = s1_mgt_q;
        s1_op_d    = s1_op_q;
        if (in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_x_d   = x_dec;
                s1_y_d   = y_dec;
                s1_mlt_d = mag_lt;
                s1_mgt_d = mag_gt;
                s1_op_d  = fcmp_op_e'(bus.op);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_mlt_q   <= 1'b0;
            s1_mgt_q   <= 1'b0;
            s1_op_q    <= OP_LT;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_mlt_q   <= s1_mlt_d;
            s1_mgt_q   <= s1_mgt_d;
            s1_op_q    <= s1_op_d;
        end
    end

    logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    logic abs_lt, abs_gt;
    logic lt_c, eq_c, gt_c, un_c, res_c;

    assign x_nan  = (s1_x_q.exc == EXC_NAN);
    assign y_nan  = (s1_y_q.exc == EXC_NAN);
    assign x_inf  = (s1_x_q.exc == EXC_INF);
    assign y_inf  = (s1_y_q.exc == EXC_INF);
    assign x_zero = (s1_x_q.exc == EXC_ZERO);
    assign y_zero = (s1_y_q.exc == EXC_ZERO);

    // Zero sign is meaningless, so zero cases are settled before any sign test.
    always_comb begin
        lt_c   = 1'b0;
        eq_c   = 1'b0;
        gt_c   = 1'b0;
        un_c   = 1'b0;
        abs_lt = 1'b0;
        abs_gt = 1'b0;
        if (x_nan || y_nan) begin
            un_c = 1'b1;
        end else if (x_zero && y_zero) begin
            eq_c = 1'b1;
        end else if (x_zero) begin
            lt_c = ~s1_y_q.sign;
            gt_c = s1_y_q.sign;
        end else if (y_zero) begin
            lt_c = s1_x_q.sign;
            gt_c = ~s1_x_q.sign;
        end else if (s1_x_q.sign != s1_y_q.sign) begin
            lt_c = s1_x_q.sign;
            gt_c = s1_y_q.sign;
        end else begin
            if (x_inf && !y_inf) begin
                abs_gt = 1'b1;
            end else if (y_inf && !x_inf) begin
                abs_lt = 1'b1;
            end else if (!x_inf) begin
                abs_lt = s1_mlt_q;
                abs_gt = s1_mgt_q;
            end
            lt_c = s1_x_q.sign ? abs_gt : abs_lt;
            gt_c = s1_x_q.sign ? abs_lt : abs_gt;
            eq_c = ~(abs_lt | abs_gt);
        end
    end

    always_comb begin
        res_c = 1'b0;
        case (s1_op_q)
            OP_LT:    res_c = lt_c;
            OP_LE:    res_c = lt_c | eq_c;
            OP_EQ:    res_c = eq_c;
            OP_NE:    res_c = ~eq_c;
            OP_GT:    res_c = gt_c;
            OP_GE:    res_c = gt_c | eq_c;
            OP_UNORD: res_c = un_c;
            OP_ORD:   res_c = ~un_c;
            default:  res_c = 1'b0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        gt_d        = gt_q;
        un_d        = un_q;
        if (s1_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = res_c;
                lt_d     = lt_c;
                eq_d     = eq_c;
                gt_d     = gt_c;
                un_d     = un_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            un_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            gt_q        <= gt_d;
            un_q        <= un_d;
        end
    end

`ifdef FCMP_UNORD_CNT_EN
    logic [15:0] unord_cnt_q, unord_cnt_d;

    always_comb begin
        unord_cnt_d = unord_cnt_q;
        if (out_valid_q && bus.out_ready && un_q && (unord_cnt_q != 16'hFFFF)) begin
            unord_cnt_d = unord_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unord_cnt_q <= 16'h0000;
        end else begin
            unord_cnt_q <= unord_cnt_d;
        end
    end

    assign bus.unord_cnt = unord_cnt_q;
`else
    assign bus.unord_cnt = 16'h0000;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.lt        = lt_q;
    assign bus.eq        = eq_q;
    assign bus.gt        = gt_q;
    assign bus.unordered = un_q;

endmodule
